stopwatch_core: RTL

Parametrised mm:ss stopwatch/timer core for the next-generation stopwatch.
- Single clock. Counting and adjust rates arrive as one-cycle tick enables, not as derived clocks.
- Adds count-down mode with expiry alarm, configurable minute limit, and edge-detected run/stop control.
- Sits between the debouncer/tick generator and the seven-segment controller; outputs BCD digits directly.

---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/stopwatch_core_bcd2_counter.sv | 44 ++++
 rtl/stopwatch_core.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the mm:ss stopwatch core: FSM states, BCD digit/pair types,
// and a compile-time integer-to-BCD converter used to build the wrap limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    STOP    = 2'd0,
    RUN     = 2'd1,
    ADJUST  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd2_t;

  localparam bcd2_t BCD_ZERO = 8'h00;

  function automatic bcd2_t to_bcd2(input int v);
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens = bcd_digit_t'(v / 10);
    ones = bcd_digit_t'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/stopwatch_core_bcd2_counter.sv
// Two-digit BCD up/down counter wrapping between 00 and a BCD limit.
// carry/borrow are combinational so a cascaded stage steps in the same cycle.
module bcd2_counter
  import stopwatch_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  inc,
  input  logic  dec,
  input  logic  zero,
  input  bcd2_t limit,
  output bcd2_t value,
  output logic  carry,
  output logic  borrow
);

  bcd2_t value_q;
  bcd2_t value_d;

  always_comb begin
    value_d = value_q;
    carry   = ~zero & inc & (value_q == limit);
    borrow  = ~zero & ~inc & dec & (value_q == BCD_ZERO);
    if (zero) begin
      value_d = BCD_ZERO;
    end else if (inc) begin
      if (value_q == limit)             value_d = BCD_ZERO;
      else if (value_q[3:0] == 4'd9)    value_d = {value_q[7:4] + 4'd1, 4'd0};
      else                              value_d = {value_q[7:4], value_q[3:0] + 4'd1};
    end else if (dec) begin
      if (value_q == BCD_ZERO)          value_d = limit;
      else if (value_q[3:0] == 4'd0)    value_d = {value_q[7:4] - 4'd1, 4'd9};
      else                              value_d = {value_q[7:4], value_q[3:0] - 4'd1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= BCD_ZERO;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/stopwatch_core.sv
// mm:ss stopwatch/timer with count-down expiry and adjust mode; BCD outputs.
// Optional lap-freeze display is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MIN_LIMIT = 99,
  parameter int SEC_LIMIT = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_run,
  input  logic       tick_adj,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       adj,
  input  logic       sel,
  input  logic       dir,
  input  logic       lap,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       alarm,
  output logic       lap_active
);

  localparam bcd2_t MIN_LIM_BCD = to_bcd2(MIN_LIMIT);
  localparam bcd2_t SEC_LIM_BCD = to_bcd2(SEC_LIMIT);

  state_e state_q, state_d;
  logic   start_prev_q, clear_prev_q;
  logic   start_rise, clear_rise;
  logic   sec_inc, sec_dec, sec_carry, sec_borrow;
  logic   min_inc, min_dec, min_carry, min_borrow;
  logic   adj_min_tick, run_step, cnt_zero, time_zero;
  bcd2_t  sec_val, min_val;

  // History resets high so a level already asserted at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= STOP;
      start_prev_q <= 1'b1;
      clear_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_stop;
      clear_prev_q <= clear;
    end
  end

  assign start_rise = start_stop & ~start_prev_q;
  assign clear_rise = clear & ~clear_prev_q;
  assign time_zero  = (min_val == BCD_ZERO) && (sec_val == BCD_ZERO);

  always_comb begin
    state_d      = state_q;
    sec_inc      = 1'b0;
    sec_dec      = 1'b0;
    adj_min_tick = 1'b0;
    run_step     = 1'b0;
    cnt_zero     = 1'b0;
    if (clear_rise) begin
      cnt_zero = 1'b1;
      state_d  = adj ? ADJUST : STOP;
    end else if (adj) begin
      state_d = ADJUST;
      if (tick_adj) begin
        if (sel) sec_inc      = 1'b1;
        else     adj_min_tick = 1'b1;
      end
    end else begin
      case (state_q)
        ADJUST: state_d = STOP;
        STOP: begin
          if (start_rise && !(dir && time_zero)) state_d = RUN;
        end
        RUN: begin
          if (tick_run) begin
            run_step = 1'b1;
            if (dir) sec_dec = 1'b1;
            else     sec_inc = 1'b1;
          end
          if (start_rise) state_d = STOP;
          // Stepping down from 00:01 lands on 00:00 this cycle.
          if (tick_run && dir && (min_val == BCD_ZERO) && (sec_val == 8'h01))
            state_d = EXPIRED;
        end
        EXPIRED: begin
          if (start_rise) state_d = STOP;
        end
        default: state_d = STOP;
      endcase
    end
  end

  // Seconds wrap in ADJUST must not ripple into minutes, hence the run_step gate.
  assign min_inc = adj_min_tick | (run_step & sec_carry);
  assign min_dec = run_step & sec_borrow;

  bcd2_counter u_sec (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (sec_inc),
    .dec    (sec_dec),
    .zero   (cnt_zero),
    .limit  (SEC_LIM_BCD),
    .value  (sec_val),
    .carry  (sec_carry),
    .borrow (sec_borrow)
  );

  bcd2_counter u_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (min_inc),
    .dec    (min_dec),
    .zero   (cnt_zero),
    .limit  (MIN_LIM_BCD),
    .value  (min_val),
    .carry  (min_carry),
    .borrow (min_borrow)
  );

  logic unused_min_flags;
  assign unused_min_flags = min_carry ^ min_borrow;

  assign running = (state_q == RUN) & ~adj;
  assign alarm   = (state_q == EXPIRED);

`ifdef STOPWATCH_LAP_EN
  logic  lap_prev_q, lap_rise;
  logic  lap_active_q, lap_active_d;
  bcd2_t hold_min_q, hold_min_d, hold_sec_q, hold_sec_d;

  assign lap_rise = lap & ~lap_prev_q;

  always_comb begin
    lap_active_d = lap_active_q;
    hold_min_d   = hold_min_q;
    hold_sec_d   = hold_sec_q;
    if (clear_rise || (state_d != RUN)) begin
      lap_active_d = 1'b0;
    end else if ((state_q == RUN) && lap_rise) begin
      lap_active_d = ~lap_active_q;
      if (!lap_active_q) begin
        hold_min_d = min_val;
        hold_sec_d = sec_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_prev_q   <= 1'b1;
      lap_active_q <= 1'b0;
      hold_min_q   <= BCD_ZERO;
      hold_sec_q   <= BCD_ZERO;
    end else begin
      lap_prev_q   <= lap;
      lap_active_q <= lap_active_d;
      hold_min_q   <= hold_min_d;
      hold_sec_q   <= hold_sec_d;
    end
  end

  assign lap_active = lap_active_q;
  assign min_bcd    = lap_active_q ? hold_min_q : min_val;
  assign sec_bcd    = lap_active_q ? hold_sec_q : sec_val;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign min_bcd    = min_val;
  assign sec_bcd    = sec_val;
`endif

  min_limit_legal: assert property (@(posedge clk) (MIN_LIMIT >= 1) && (MIN_LIMIT <= 99));
  sec_limit_legal: assert property (@(posedge clk) (SEC_LIMIT >= 1) && (SEC_LIMIT <= 59));

endmodule
